// File: rtl/ddr3_arbiter.sv
// Purpose: shares one DDR3 controller user interface between a single-beat write stream and a read-burst stream (reads first).
// Latency: grant registered 1 cycle after the IDLE decision; read data forwarded 1 cycle after app_rd_data_valid.
// Backpressure: app_rdy / app_wdf_rdy stall command and write-data issue; requesters hold until their ack.
//
// Ports:
//   ui_clk, ui_clk_sync_rst      clock, async active-high reset
//   calib_done                   no grants until high
//   wr_req/wr_addr/wr_data/wr_ack          write beat request, ack pulses once accepted
//   rd_req/rd_addr/rd_len/rd_ack           read burst request, ack pulses at grant
//   rd_data/rd_valid/rd_done               returned beats, done pulses with the last one
//   app_*                        controller user interface
module ddr3_arbiter #(
    parameter logic [27:0] ADDR_LAST  = 28'd786424,
    parameter int          MAX_LEN    = 16,
    parameter int          MAX_RD_RUN = 4
) (
    input  logic         ui_clk,
    input  logic         ui_clk_sync_rst,
    input  logic         calib_done,
    input  logic         wr_req,
    input  logic [27:0]  wr_addr,
    input  logic [127:0] wr_data,
    output logic         wr_ack,
    input  logic         rd_req,
    input  logic [27:0]  rd_addr,
    input  logic [4:0]   rd_len,
    output logic         rd_ack,
    output logic [127:0] rd_data,
    output logic         rd_valid,
    output logic         rd_done,
    output logic [27:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic         app_wdf_wren,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid
);

    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DRAIN} state_t;

    localparam int              RUN_W   = $clog2(MAX_RD_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);
    localparam logic [4:0]      LEN_MAX = 5'(MAX_LEN);
    localparam logic [2:0]      CMD_WR  = 3'b000;
    localparam logic [2:0]      CMD_RD  = 3'b001;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [4:0]       remaining;
    logic [4:0]       expected;
    logic             cmd_done;
    logic             dat_done;

    logic [4:0]  len_eff;
    logic [27:0] addr_next;
    logic        grant_rd;
    logic        grant_wr;
    logic        cmd_fin;
    logic        dat_fin;
    logic        beat_in;
    logic        last_beat;

    // Zero-length bursts are promoted to one beat; oversize ones are clipped.
    assign len_eff = (rd_len == 5'd0)   ? 5'd1 :
                     (rd_len > LEN_MAX) ? LEN_MAX : rd_len;

    // app_addr doubles as the burst address register.
    assign addr_next = (app_addr == ADDR_LAST) ? 28'd0 : app_addr + 28'd8;

    // The wr_ack cycle is skipped: the writer still holds wr_req while it sees the ack.
    assign grant_rd = (state == IDLE) && calib_done && !wr_ack && rd_req &&
                      (!wr_req || (run_cnt < RUN_MAX));
    assign grant_wr = (state == IDLE) && calib_done && !wr_ack && wr_req && !grant_rd;

    // Write command and write data handshakes complete independently.
    assign cmd_fin = cmd_done | (app_en & app_rdy);
    assign dat_fin = dat_done | (app_wdf_wren & app_wdf_rdy);

    // Beats arriving with no burst outstanding (e.g. after a reset) are dropped.
    assign beat_in   = app_rd_data_valid && (expected != 5'd0);
    assign last_beat = beat_in && (expected == 5'd1);

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            state        <= IDLE;
            run_cnt      <= '0;
            remaining    <= '0;
            expected     <= '0;
            cmd_done     <= 1'b0;
            dat_done     <= 1'b0;
            wr_ack       <= 1'b0;
            rd_ack       <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            rd_done      <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_wren <= 1'b0;
        end else begin
            wr_ack   <= 1'b0;
            rd_ack   <= 1'b0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;

            // Return path runs regardless of state so data is never lost.
            if (beat_in) begin
                rd_valid <= 1'b1;
                rd_data  <= app_rd_data;
                expected <= expected - 5'd1;
                rd_done  <= last_beat;
            end

            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        rd_ack    <= 1'b1;
                        app_en    <= 1'b1;
                        app_cmd   <= CMD_RD;
                        app_addr  <= rd_addr;
                        remaining <= len_eff;
                        expected  <= len_eff;
                        run_cnt   <= wr_req ? run_cnt + RUN_W'(1) : '0;
                        state     <= RD_ISSUE;
                    end else if (grant_wr) begin
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                        app_cmd      <= CMD_WR;
                        app_addr     <= wr_addr;
                        app_wdf_data <= wr_data;
                        run_cnt      <= '0;
                        state        <= WR;
                    end
                end

                WR: begin
                    app_en       <= !cmd_fin;
                    app_wdf_wren <= !dat_fin;
                    cmd_done     <= cmd_fin;
                    dat_done     <= dat_fin;
                    if (cmd_fin && dat_fin) begin
                        wr_ack   <= 1'b1;
                        cmd_done <= 1'b0;
                        dat_done <= 1'b0;
                        state    <= IDLE;
                    end
                end

                RD_ISSUE: begin
                    if (app_rdy) begin
                        remaining <= remaining - 5'd1;
                        app_addr  <= addr_next;
                        if (remaining == 5'd1) begin
                            app_en <= 1'b0;
                            state  <= last_beat ? IDLE : RD_DRAIN;
                        end
                    end
                end

                RD_DRAIN: begin
                    if (last_beat) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_arbiter.sv
module tb_ddr3_arbiter;

    localparam logic [27:0] ADDR_LAST = 28'd786424;

    logic         ui_clk = 1'b0;
    logic         ui_clk_sync_rst = 1'b1;
    logic         calib_done = 1'b0;
    logic         wr_req = 1'b0;
    logic [27:0]  wr_addr = '0;
    logic [127:0] wr_data = '0;
    logic         wr_ack;
    logic         rd_req = 1'b0;
    logic [27:0]  rd_addr = '0;
    logic [4:0]   rd_len = '0;
    logic         rd_ack;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_done;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy = 1'b1;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_rdy = 1'b1;
    logic [127:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0;

    always #5 ui_clk = ~ui_clk;

    ddr3_arbiter dut (
        .ui_clk            (ui_clk),
        .ui_clk_sync_rst   (ui_clk_sync_rst),
        .calib_done        (calib_done),
        .wr_req            (wr_req),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_ack            (wr_ack),
        .rd_req            (rd_req),
        .rd_addr           (rd_addr),
        .rd_len            (rd_len),
        .rd_ack            (rd_ack),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_done           (rd_done),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [127:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, required no such event", name, act);
    endtask

    function automatic logic [127:0] beat_of(input logic [27:0] a);
        return {4{4'h5, a}};
    endfunction

    function automatic logic [27:0] next_addr(input logic [27:0] a);
        return (a == ADDR_LAST) ? 28'd0 : a + 28'd8;
    endfunction

    // Scoreboard queues
    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } beat_t;

    logic [27:0] pend_q[$];     // controller model: accepted reads awaiting return
    logic [27:0] exp_cmd_q[$];  // expected read command addresses
    beat_t       exp_q[$];      // expected returned beats
    beat_t       mon_b;
    int          cmd_cnt = 0;
    int          rv_cnt = 0;
    int          rd_done_cnt = 0;
    logic [27:0] last_cmd_addr = '0;
    logic        ret_en = 1'b1;

    task automatic push_read(input logic [27:0] addr, input logic [4:0] len);
        logic [27:0] a;
        int n;
        a = addr;
        n = (len == 5'd0) ? 1 : int'(len);
        for (int i = 0; i < n; i++) begin
            exp_cmd_q.push_back(a);
            exp_q.push_back({beat_of(a), (i == n - 1) ? 1'b1 : 1'b0});
            a = next_addr(a);
        end
    endtask

    // Controller model: returns read data in order, at least one cycle after accept.
    initial begin
        forever begin
            @(negedge ui_clk);
            #1;
            if (ui_clk_sync_rst) begin
                pend_q.delete();
                app_rd_data_valid = 1'b0;
            end else begin
                if (ret_en && pend_q.size() > 0) begin
                    app_rd_data_valid = 1'b1;
                    app_rd_data = beat_of(pend_q.pop_front());
                end else begin
                    app_rd_data_valid = 1'b0;
                end
                if (app_en && app_rdy && app_cmd == 3'b001) begin
                    pend_q.push_back(app_addr);
                    cmd_cnt++;
                    last_cmd_addr = app_addr;
                    if (exp_cmd_q.size() == 0) fail_evt("cmd_unexpected", app_addr);
                    else check("cmd_addr", app_addr, exp_cmd_q.pop_front());
                end
            end
        end
    end

    // Read return monitor
    initial begin
        forever begin
            @(negedge ui_clk);
            if (rd_valid) begin
                rv_cnt++;
                if (exp_q.size() == 0) begin
                    fail_evt("rd_valid_unexpected", rd_data);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("rd_data", rd_data, mon_b.data);
                    check("rd_done_align", rd_done, mon_b.last);
                end
            end else if (rd_done) begin
                fail_evt("rd_done_alone", rd_done);
            end
            if (rd_done) rd_done_cnt++;
        end
    end

    task automatic do_read(input logic [27:0] addr, input logic [4:0] len, input bit toggle,
                           output int lat, output int ncmd, output int nval, output int ndone,
                           output logic [27:0] last_a);
        int c0, v0, d0, t;
        push_read(addr, len);
        c0 = cmd_cnt; v0 = rv_cnt; d0 = rd_done_cnt;
        rd_req = 1'b1; rd_addr = addr; rd_len = len; app_rdy = 1'b1;
        lat = 0;
        do begin
            @(negedge ui_clk);
            lat++;
        end while (!rd_ack && lat < 50);
        if (!rd_ack) fail_evt("rd_ack_timeout", addr);
        rd_req = 1'b0;
        t = 0;
        while (rd_done_cnt == d0 && t < 200) begin
            if (toggle) app_rdy = ~app_rdy;
            @(negedge ui_clk);
            t++;
        end
        if (rd_done_cnt == d0) fail_evt("rd_done_timeout", addr);
        app_rdy = 1'b1;
        repeat (3) @(negedge ui_clk);
        ncmd = cmd_cnt - c0; nval = rv_cnt - v0; ndone = rd_done_cnt - d0;
        last_a = last_cmd_addr;
    endtask

    typedef struct {
        logic [27:0] addr;
        logic [4:0]  len;
        bit          toggle;
        int          exp_ncmd;
        logic [27:0] exp_last;
    } rd_vec_t;

    typedef struct {
        logic [27:0]  addr;
        logic [127:0] data;
        int           cmd_dly;
        int           dat_dly;
        int           exp_en;
        int           exp_wren;
        int           exp_ack_k;
    } wr_vec_t;

    task automatic do_write(input wr_vec_t v);
        int lat, en_c, wren_c, ack_k, acks;
        en_c = 0; wren_c = 0; ack_k = -1; acks = 0;
        wr_req = 1'b1; wr_addr = v.addr; wr_data = v.data;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        lat = 0;
        do begin
            @(negedge ui_clk);
            lat++;
        end while (!app_en && lat < 50);
        if (!app_en) fail_evt("wr_grant_timeout", v.addr);
        check("wr_grant_lat", lat, 1);
        check("wr_app_addr", app_addr, v.addr);
        check("wr_app_cmd", app_cmd, 3'b000);
        check("wr_wdf_data", app_wdf_data, v.data);
        for (int k = 0; k < 12; k++) begin
            if (app_en) en_c++;
            if (app_wdf_wren) wren_c++;
            if (wr_ack) begin
                acks++;
                ack_k = k;
                wr_req = 1'b0;
            end
            app_rdy = (k >= v.cmd_dly);
            app_wdf_rdy = (k >= v.dat_dly);
            @(negedge ui_clk);
        end
        check("wr_en_cycles", en_c, v.exp_en);
        check("wr_wren_cycles", wren_c, v.exp_wren);
        check("wr_ack_cycle", ack_k, v.exp_ack_k);
        check("wr_ack_count", acks, 1);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {app_en, app_wdf_wren, rd_ack, wr_ack, rd_valid, rd_done}, 6'b0);
        check({tag, "_app_addr"}, app_addr, 28'd0);
        check({tag, "_app_cmd"}, app_cmd, 3'd0);
        check({tag, "_wdf_data"}, app_wdf_data, 128'd0);
        check({tag, "_rd_data"}, rd_data, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t     rv[6];
        wr_vec_t     wv[4];
        int          lat, ncmd, nval, ndone, seen, d0, v0, t;
        logic [27:0] last_a;
        logic        g[10];
        logic        exp_g[10];
        int          ng;

        rv[0] = '{ADDR_LAST - 28'd8, 5'd3, 1'b0, 3, 28'd0};
        rv[1] = '{28'h40, 5'd1, 1'b0, 1, 28'h40};
        rv[2] = '{28'h100, 5'd0, 1'b0, 1, 28'h100};
        rv[3] = '{28'h800, 5'd16, 1'b0, 16, 28'h878};
        rv[4] = '{28'h1000, 5'd8, 1'b1, 8, 28'h1038};
        rv[5] = '{ADDR_LAST, 5'd3, 1'b1, 3, 28'h8};

        wv[0] = '{28'h40, {16{8'hA5}}, 0, 0, 1, 1, 1};
        wv[1] = '{28'h80, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 3, 1, 4, 4};
        wv[2] = '{28'hC0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 2, 0, 3, 1, 3};
        wv[3] = '{28'h100, 128'h1, 1, 1, 2, 2, 2};

        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge ui_clk);
        check_zero("reset");
        ui_clk_sync_rst = 1'b0;
        @(negedge ui_clk);

        // No grant while calibration is pending
        rd_req = 1'b1; rd_addr = 28'h500; rd_len = 5'd1;
        seen = 0;
        repeat (6) begin
            @(negedge ui_clk);
            if (rd_ack || app_en) seen++;
        end
        check("calib_hold", seen, 0);
        rd_req = 1'b0;
        calib_done = 1'b1;
        do_read(28'h500, 5'd1, 1'b0, lat, ncmd, nval, ndone, last_a);
        check("calib_rd_lat", lat, 1);
        check("calib_rd_ncmd", ncmd, 1);

        // Read burst table
        for (int i = 0; i < 6; i++) begin
            do_read(rv[i].addr, rv[i].len, rv[i].toggle, lat, ncmd, nval, ndone, last_a);
            check("rd_grant_lat", lat, 1);
            check("rd_ncmd", ncmd, rv[i].exp_ncmd);
            check("rd_nvalid", nval, rv[i].exp_ncmd);
            check("rd_ndone", ndone, 1);
            check("rd_last_addr", last_a, rv[i].exp_last);
        end

        // Write table
        for (int i = 0; i < 4; i++) do_write(wv[i]);

        // Both requesters held: reads limited to 4 in a row while a write waits
        rd_addr = 28'h2000; rd_len = 5'd1; rd_req = 1'b1;
        wr_addr = 28'h3000; wr_data = 128'hCAFE; wr_req = 1'b1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        ng = 0; t = 0;
        while (ng < 10 && t < 400) begin
            @(negedge ui_clk);
            t++;
            if (rd_ack) begin
                push_read(28'h2000, 5'd1);
                g[ng] = 1'b1;
                ng++;
            end
            if (wr_ack && ng < 10) begin
                g[ng] = 1'b0;
                ng++;
            end
        end
        rd_req = 1'b0; wr_req = 1'b0;
        check("arb_grants", ng, 10);
        for (int i = 0; i < 10; i++) check("arb_grant_seq", g[i], exp_g[i]);
        repeat (10) @(negedge ui_clk);
        check("arb_drained", exp_q.size(), 0);

        // Reset in the middle of a 5-beat burst after 2 beats returned
        ret_en = 1'b0;
        push_read(28'h200, 5'd5);
        rd_req = 1'b1; rd_addr = 28'h200; rd_len = 5'd5;
        t = 0;
        do begin
            @(negedge ui_clk);
            t++;
        end while (!rd_ack && t < 50);
        if (!rd_ack) fail_evt("rst_rd_ack_timeout", 28'h200);
        rd_req = 1'b0;
        repeat (8) @(negedge ui_clk);
        v0 = rv_cnt; d0 = rd_done_cnt;
        ret_en = 1'b1;
        repeat (2) @(negedge ui_clk);
        ret_en = 1'b0;
        repeat (2) @(negedge ui_clk);
        check("rst_beats_before", rv_cnt - v0, 2);
        #2 ui_clk_sync_rst = 1'b1;
        #1 check_zero("async_rst");
        exp_q.delete();
        exp_cmd_q.delete();
        repeat (2) @(negedge ui_clk);
        ui_clk_sync_rst = 1'b0;
        ret_en = 1'b1;
        repeat (5) @(negedge ui_clk);
        check("rst_no_done", rd_done_cnt - d0, 0);
        do_read(28'h300, 5'd2, 1'b0, lat, ncmd, nval, ndone, last_a);
        check("post_rst_lat", lat, 1);
        check("post_rst_ncmd", ncmd, 2);
        check("post_rst_nvalid", nval, 2);
        check("post_rst_last", last_a, 28'h308);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr3_arbiter.md
# ddr3_arbiter

Shares the single DDR3 controller user interface between the fractal write stream and the VGA prefetch read stream, in the ui_clk domain. Write requests are single 128-bit beats; read requests are bursts of consecutive 128-bit beats whose return data is forwarded in order. Reads have priority because of the display deadline. A starvation guard keeps the compute engine moving during long display fetches.

## Interface
- ADDR_LAST, 28'd786424: highest beat address; the next address after it wraps to 0.
- MAX_LEN, 16: maximum beats per read burst (rd_len range 1..MAX_LEN).
- MAX_RD_RUN, 4: maximum consecutive read bursts granted while a write is pending.

Ports:
- ui_clk  in  1  controller user clock; all logic on rising edge.
- ui_clk_sync_rst  in  1  reset, asynchronous, active-high.
- calib_done  in  1  controller calibration complete; no grant before it is high.
- wr_req  in  1  write request; held high with wr_addr/wr_data until wr_ack.
- wr_addr  in  28  write beat address, multiple of 8.
- wr_data  in  128  write beat data.
- wr_ack  out  1  one-cycle pulse: write beat accepted by the controller.
- rd_req  in  1  read burst request; held with rd_addr/rd_len until rd_ack.
- rd_addr  in  28  first beat address, multiple of 8.
- rd_len  in  5  beat count, 1..MAX_LEN.
- rd_ack  out  1  one-cycle pulse: burst granted, inputs captured.
- rd_data  out  128  returned beat data.
- rd_valid  out  1  rd_data qualifier, one cycle per beat.
- rd_done  out  1  one-cycle pulse with the last rd_valid of a burst.
- app_addr  out  28  controller address.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted when high with app_en.
- app_wdf_data  out  128  write data.
- app_wdf_wren  out  1  write data valid; app_wdf_end is tied to 1 outside this block.
- app_wdf_rdy  in  1  write data accepted when high with app_wdf_wren.
- app_rd_data  in  128  controller read data.
- app_rd_data_valid  in  1  controller read data qualifier.

## Operation
- States: IDLE, WR (write in flight), RD_ISSUE (issuing burst commands), RD_DRAIN (waiting for the remaining return data).
- IDLE with calib_done=1 chooses the next grant:
  - rd_req and no pending write -> read.
  - rd_req with wr_req and run_cnt < MAX_RD_RUN -> read.
  - Otherwise wr_req -> write.
- Grant effects:
  - Read: increments run_cnt when wr_req is high.
  - Write: clears run_cnt.
  - Read with wr_req low: clears run_cnt.
- WR:
  - Drive app_en=1, app_wdf_wren=1, app_cmd=000, app_addr=wr_addr, app_wdf_data=wr_data.
  - Drop app_en on the cycle after app_en&app_rdy.
  - Drop app_wdf_wren on the cycle after app_wdf_wren&app_wdf_rdy.
  - Either handshake may complete first.
  - When both have completed: pulse wr_ack, return to IDLE.
- Read grant:
  - Pulse rd_ack.
  - Latch addr=rd_addr, remaining=rd_len, expected=rd_len.
  - Enter RD_ISSUE.
- RD_ISSUE:
  - app_en=1, app_cmd=001, app_addr=addr.
  - On each app_rdy: remaining decrements; addr becomes addr+8, or 0 if addr==ADDR_LAST.
  - On the final accept: app_en drops, enter RD_DRAIN.
- Read return data, in any state:
  - Each app_rd_data_valid is forwarded the next cycle as rd_valid/rd_data and decrements expected.
  - When the final beat is forwarded: rd_done pulses with it, and the state goes RD_DRAIN -> IDLE.
- Only one transaction is outstanding at a time. Writes never interleave inside a burst.
- rd_len=0 is illegal. It is treated as 1.

## Timing
- Reset values: all outputs 0; state IDLE; run_cnt, remaining and expected cleared.
- Reset mid-operation: outstanding beats are discarded; no rd_done is emitted; app_en and app_wdf_wren drop immediately.
- Grant to interface:
  - IDLE decision cycle N: rd_ack/app_en (or app_en/app_wdf_wren for a write) are registered high at N+1.
  - A read burst of L beats with app_rdy held high issues L commands on consecutive cycles N+1..N+L.
- Write with both rdy high: app_en high for 1 cycle; wr_ack at N+2; next grant decision at N+3.
- Read data latency: rd_valid appears exactly 1 cycle after app_rd_data_valid; beat order is preserved.
- calib_done low: stay in IDLE with no acks. If calib_done falls mid-transaction, the transaction completes.
- Simultaneous rd_req and wr_req with run_cnt==MAX_RD_RUN: write wins; run_cnt clears.

## Test plan
- Write only, app_rdy=app_wdf_rdy=1, wr_addr=0x40, wr_data=0xA5.. -> app_en 1 cycle with app_cmd=000, app_addr=0x40; wr_ack exactly once.
- Write with app_wdf_rdy delayed 3 cycles after app_rdy -> app_en drops after 1 cycle; app_wdf_wren is held 4 cycles; wr_ack follows the later handshake.
- Read rd_addr=ADDR_LAST-8, rd_len=3 -> app_addr sequence ADDR_LAST-8, ADDR_LAST, 0; 3 rd_valid; rd_done coincides with the third.
- wr_req and rd_req both held continuously, MAX_RD_RUN=4 -> 4 read bursts, then 1 write, repeating; no write waits more than 4 bursts.
- app_rdy toggling 1-0-1-0 during an 8-beat burst -> exactly 8 commands issued, addresses contiguous, 8 rd_valid, no duplicates.
- ui_clk_sync_rst asserted after 2 of 5 read beats returned -> all outputs 0 asynchronously; no rd_done; the next grant after release works normally.
